alpha_u_packer: RTL

Upstream input stage for `backbone_initial`. It takes a serial stream of IEEE-754 double `alpha_u` coefficients, one 64-bit word per beat, and assembles the full J×A coefficient vector in a shadow buffer. It checks frame framing with `s_tlast` and publishes each complete vector to the flat `alpha_u` bus with a single-cycle `alpha_u_tvalid` pulse. The output bus connects directly to the `alpha_u` / `alpha_u_tvalid` inputs of `backbone_initial`.

---
 rtl/alpha_u_packer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alpha_u_packer.sv
// Serial-to-parallel packer for the alpha_u coefficient vector feeding backbone_initial.
// Beats fill a shadow buffer; a complete, correctly framed vector is published in one cycle.
module alpha_u_packer #(
    parameter int J = 14,
    parameter int A = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic              busy,
    output logic [J*A*64-1:0] alpha_u,
    output logic              alpha_u_tvalid,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);
    localparam int N       = J * A;
    localparam int K_WIDTH = $clog2(N) + 1;

    localparam logic [1:0] FILL    = 2'd0;
    localparam logic [1:0] PEND    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(N - 1);

    logic [1:0]         state_r;
    logic [1:0]         state_next_s;
    logic [K_WIDTH-1:0] k_r;
    logic [K_WIDTH-1:0] k_next_s;
    logic               err_next_s;
    logic               publish_s;
    logic               wr_s;
    logic               accept_s;
    logic [63:0]        shadow_r [N];
    logic [N*64-1:0]    shadow_flat_s;

    assign accept_s = s_tvalid && s_tready;

    // Next-state, beat counter and framing-error decisions
    always_comb begin
        state_next_s = state_r;
        k_next_s     = k_r;
        err_next_s   = 1'b0;
        publish_s    = 1'b0;
        wr_s         = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    wr_s = 1'b1;
                    if (k_r == K_LAST) begin
                        k_next_s = {K_WIDTH{1'b0}};
                        if (s_tlast) begin
                            state_next_s = PEND;
                        end else begin
                            err_next_s   = 1'b1;
                            state_next_s = DISCARD;
                        end
                    end else if (s_tlast) begin
                        // Early tlast: the partial frame is abandoned in place.
                        err_next_s = 1'b1;
                        k_next_s   = {K_WIDTH{1'b0}};
                    end else begin
                        k_next_s = k_r + K_WIDTH'(1);
                    end
                end else begin
                    k_next_s = k_r;
                end
            end
            PEND: begin
                if (!busy) begin
                    publish_s    = 1'b1;
                    state_next_s = FILL;
                end else begin
                    state_next_s = PEND;
                end
            end
            DISCARD: begin
                if (accept_s && s_tlast) begin
                    state_next_s = FILL;
                    k_next_s     = {K_WIDTH{1'b0}};
                end else begin
                    state_next_s = DISCARD;
                end
            end
            default: begin
                state_next_s = FILL;
                k_next_s     = {K_WIDTH{1'b0}};
            end
        endcase
    end

    // Flatten the shadow buffer into the output bus layout
    always_comb begin
        shadow_flat_s = {(N*64){1'b0}};
        for (int i = 0; i < N; i++) begin
            shadow_flat_s[64*i +: 64] = shadow_r[i];
        end
    end

    // Shadow buffer write; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_s) begin
            shadow_r[k_r[K_WIDTH-2:0]] <= s_tdata;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= FILL;
            k_r            <= {K_WIDTH{1'b0}};
            s_tready       <= 1'b1;
            alpha_u        <= {(N*64){1'b0}};
            alpha_u_tvalid <= 1'b0;
            frame_err      <= 1'b0;
            frame_cnt      <= 16'd0;
        end else begin
            state_r        <= state_next_s;
            k_r            <= k_next_s;
            s_tready       <= (state_next_s != PEND);
            alpha_u_tvalid <= publish_s;
            frame_err      <= err_next_s;
            if (publish_s) begin
                alpha_u   <= shadow_flat_s;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                alpha_u   <= alpha_u;
                frame_cnt <= frame_cnt;
            end
        end
    end
endmodule
